// File: rtl/stop_watch_uart_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stop_watch_uart_ctrl_if : UART rx/tx FIFO handshake bundle  rev 1.0 |
// +--------------------------------------------------------------------+
interface stop_watch_uart_ctrl_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;

  // master = command controller, slave = UART core
  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, wr_uart, w_data
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, wr_uart, w_data
  );
endinterface
`default_nettype wire

// File: rtl/stop_watch_uart_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stop_watch_uart_ctrl : ASCII command decoder / time reporter rev 1.0|
// +--------------------------------------------------------------------+
module stop_watch_uart_ctrl #(
  parameter int CRLF  = 1,
  parameter int ERR_W = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  stop_watch_uart_ctrl_if.master uart,
  input  wire logic [3:0]       d,
  input  wire logic [3:0]       s0,
  input  wire logic [2:0]       s1,
  input  wire logic [3:0]       m,
  output logic                  up,
  output logic                  go,
  output logic                  clr,
  output logic                  busy,
  output logic [ERR_W-1:0]      err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  localparam logic [2:0]       c_LAST_IDX = (CRLF != 0) ? 3'd7 : 3'd5;
  localparam logic [ERR_W-1:0] c_ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] c_ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [7:0]       r_cmd;
  logic [3:0]       r_m;
  logic [2:0]       r_s1;
  logic [3:0]       r_s0;
  logic [3:0]       r_d;
  logic [2:0]       r_idx;
  logic             r_up;
  logic             r_go;
  logic             r_clr;
  logic [ERR_W-1:0] r_err;

  logic [7:0]       w_lc;
  logic             w_blank;
  logic [7:0]       w_char;
  logic             w_pop;
  logic             w_push;

  // Setting bit 5 folds upper-case letters onto lower case; only letters alias.
  assign w_lc    = r_cmd | 8'h20;
  assign w_blank = (r_cmd == 8'h0D) || (r_cmd == 8'h0A) || (r_cmd == 8'h20);

  assign w_pop  = (r_state == ST_IDLE) && !uart.rx_empty;
  assign w_push = (r_state == ST_SEND) && !uart.tx_full;

  always_comb begin
    w_char = 8'h00;
    case (r_idx)
      3'd0:    w_char = 8'h30 + {4'b0000, r_m};
      3'd1:    w_char = 8'h2E;
      3'd2:    w_char = 8'h30 + {5'b00000, r_s1};
      3'd3:    w_char = 8'h30 + {4'b0000, r_s0};
      3'd4:    w_char = 8'h2E;
      3'd5:    w_char = 8'h30 + {4'b0000, r_d};
      3'd6:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end

  assign uart.rd_uart = w_pop;
  assign uart.wr_uart = w_push;
  assign uart.w_data  = (r_state == ST_SEND) ? w_char : 8'h00;

  assign up      = r_up;
  assign go      = r_go;
  assign clr     = r_clr;
  assign err_cnt = r_err;
  assign busy    = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= 8'h00;
      r_m     <= 4'd0;
      r_s1    <= 3'd0;
      r_s0    <= 4'd0;
      r_d     <= 4'd0;
      r_idx   <= 3'd0;
      r_up    <= 1'b1;
      r_go    <= 1'b0;
      r_clr   <= 1'b0;
      r_err   <= '0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cmd   <= uart.r_data;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          r_state <= ST_IDLE;
          if (!w_blank) begin
            case (w_lc)
              8'h67: r_go  <= 1'b1;
              8'h70: r_go  <= 1'b0;
              8'h75: r_up  <= 1'b1;
              8'h64: r_up  <= 1'b0;
              8'h63: r_clr <= 1'b1;
              8'h74: r_go  <= ~r_go;
              8'h72: begin
                r_m     <= m;
                r_s1    <= s1;
                r_s0    <= s0;
                r_d     <= d;
                r_idx   <= 3'd0;
                r_state <= ST_SEND;
              end
              default: begin
                if (r_err != c_ERR_MAX) r_err <= r_err + c_ERR_ONE;
              end
            endcase
          end
        end

        ST_SEND: begin
          if (w_push) begin
            if (r_idx == c_LAST_IDX) begin
              r_state <= ST_IDLE;
              r_idx   <= 3'd0;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stop_watch_uart_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stop_watch_uart_ctrl : directed bench for the command ctrl rev 1.0|
// +--------------------------------------------------------------------+
module tb_stop_watch_uart_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] d, s0, m;
  logic [2:0] s1;
  logic       up, go, clr, busy;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  stop_watch_uart_ctrl_if ifc ();

  stop_watch_uart_ctrl #(.CRLF(1), .ERR_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .uart    (ifc.master),
    .d       (d),
    .s0      (s0),
    .s1      (s1),
    .m       (m),
    .up      (up),
    .go      (go),
    .clr     (clr),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Pops one byte and lets DECODE finish; results are visible on return.
  task automatic cmd(input logic [7:0] b);
    ifc.rx_empty = 1'b0;
    ifc.r_data   = b;
    next_cycle();
    ifc.rx_empty = 1'b1;
    next_cycle();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    ifc.rx_empty = 1'b1;
    ifc.r_data   = 8'h00;
    ifc.tx_full  = 1'b0;
    m = 4'd0; s1 = 3'd0; s0 = 4'd0; d = 4'd0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (go !== 1'b0)  begin n_errors++; $display("FAIL reset_go got %b exp 0", go); end
    n_checks++; if (up !== 1'b1)  begin n_errors++; $display("FAIL reset_up got %b exp 1", up); end
    n_checks++; if (clr !== 1'b0) begin n_errors++; $display("FAIL reset_clr got %b exp 0", clr); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
    n_checks++; if (ifc.rd_uart !== 1'b0) begin n_errors++; $display("FAIL reset_rd got %b exp 0", ifc.rd_uart); end
    n_checks++; if (ifc.wr_uart !== 1'b0) begin n_errors++; $display("FAIL reset_wr got %b exp 0", ifc.wr_uart); end
    n_checks++; if (ifc.w_data !== 8'h00) begin n_errors++; $display("FAIL reset_wdata got %h exp 00", ifc.w_data); end
    next_cycle();
  endtask

  task automatic test_go();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin ifc.rx_empty = 1'b0; ifc.r_data = 8'h67; end
      @(negedge clk);
      n_checks++; if (ifc.rd_uart !== (k == 0)) begin n_errors++; $display("FAIL go_rd c%0d got %b exp %b", k, ifc.rd_uart, k == 0); end
      n_checks++; if (go !== (k >= 2)) begin n_errors++; $display("FAIL go_go c%0d got %b exp %b", k, go, k >= 2); end
      n_checks++; if (up !== 1'b1 || clr !== 1'b0) begin n_errors++; $display("FAIL go_upclr c%0d got up=%b clr=%b exp 1/0", k, up, clr); end
      next_cycle();
      ifc.rx_empty = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int h;
    logic rd_act;
    bytes[0] = 8'h47; bytes[1] = 8'h64; bytes[2] = 8'h63;
    h = 0;
    for (int k = 0; k < 8; k++) begin
      ifc.rx_empty = (h >= 3);
      ifc.r_data   = (h < 3) ? bytes[h] : 8'h00;
      @(negedge clk);
      rd_act = ifc.rd_uart;
      n_checks++; if (rd_act !== (k == 0 || k == 2 || k == 4)) begin n_errors++; $display("FAIL b2b_rd c%0d got %b", k, rd_act); end
      n_checks++; if (clr !== (k == 6)) begin n_errors++; $display("FAIL b2b_clr c%0d got %b exp %b", k, clr, k == 6); end
      next_cycle();
      if (rd_act === 1'b1) h++;
    end
    ifc.rx_empty = 1'b1;
    n_checks++; if (go !== 1'b1 || up !== 1'b0) begin n_errors++; $display("FAIL b2b_final got go=%b up=%b exp 1/0", go, up); end
    n_checks++; if (h !== 3) begin n_errors++; $display("FAIL b2b_pops got %0d exp 3", h); end
  endtask

  task automatic test_ignore();
    cmd(8'h0D); cmd(8'h0A); cmd(8'h20);
    n_checks++; if (err_cnt !== 8'd0) begin n_errors++; $display("FAIL ignore_err got %0d exp 0", err_cnt); end
    n_checks++; if (go !== 1'b1 || up !== 1'b0) begin n_errors++; $display("FAIL ignore_ctl got go=%b up=%b exp 1/0", go, up); end
    cmd(8'h5A);
    n_checks++; if (err_cnt !== 8'd1) begin n_errors++; $display("FAIL unknown_err got %0d exp 1", err_cnt); end
  endtask

  task automatic test_misc();
    cmd(8'h75);
    n_checks++; if (up !== 1'b1) begin n_errors++; $display("FAIL cmd_u got %b exp 1", up); end
    cmd(8'h74);
    n_checks++; if (go !== 1'b0) begin n_errors++; $display("FAIL cmd_t1 got %b exp 0", go); end
    cmd(8'h54);
    n_checks++; if (go !== 1'b1) begin n_errors++; $display("FAIL cmd_T2 got %b exp 1", go); end
    cmd(8'h50);
    n_checks++; if (go !== 1'b0) begin n_errors++; $display("FAIL cmd_P got %b exp 0", go); end
    cmd(8'h67); cmd(8'h44);
    n_checks++; if (go !== 1'b1 || up !== 1'b0) begin n_errors++; $display("FAIL cmd_gD got go=%b up=%b exp 1/0", go, up); end
  endtask

  // Report of 3.47.2 with an optional back-pressure window after stall_at bytes.
  task automatic test_report(input int stall_at, input int stall_len);
    logic [7:0] exp_b [8];
    int n, rem, cyc, na;
    exp_b[0] = 8'h33; exp_b[1] = 8'h2E; exp_b[2] = 8'h34; exp_b[3] = 8'h37;
    exp_b[4] = 8'h2E; exp_b[5] = 8'h32; exp_b[6] = 8'h0D; exp_b[7] = 8'h0A;
    m = 4'd3; s1 = 3'd4; s0 = 4'd7; d = 4'd2;
    ifc.rx_empty = 1'b0; ifc.r_data = 8'h52;
    @(negedge clk);
    n_checks++; if (ifc.rd_uart !== 1'b1) begin n_errors++; $display("FAIL rep_rd got %b exp 1", ifc.rd_uart); end
    next_cycle();
    ifc.rx_empty = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || ifc.wr_uart !== 1'b0) begin n_errors++; $display("FAIL rep_decode got busy=%b wr=%b exp 1/0", busy, ifc.wr_uart); end
    next_cycle();
    n = 0; rem = stall_len; cyc = 0; na = 0;
    while (n < 8 && cyc < 40) begin
      ifc.tx_full = (n == stall_at) && (rem > 0);
      if (cyc == 1) begin m = 4'd9; s1 = 3'd5; s0 = 4'd0; d = 4'd8; end
      @(negedge clk);
      if (ifc.wr_uart === 1'b1) na++;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rep_busy c%0d got %b exp 1", cyc, busy); end
      if (ifc.tx_full) begin
        n_checks++; if (ifc.wr_uart !== 1'b0) begin n_errors++; $display("FAIL rep_stall_wr c%0d got %b exp 0", cyc, ifc.wr_uart); end
        rem--;
      end else begin
        n_checks++;
        if (ifc.wr_uart !== 1'b1 || ifc.w_data !== exp_b[n]) begin
          n_errors++; $display("FAIL rep_byte%0d got wr=%b data=%h exp 1/%h", n, ifc.wr_uart, ifc.w_data, exp_b[n]);
        end
        n++;
      end
      next_cycle();
      cyc++;
    end
    ifc.tx_full = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ifc.wr_uart !== 1'b0 || ifc.w_data !== 8'h00) begin
      n_errors++; $display("FAIL rep_end got busy=%b wr=%b data=%h exp 0/0/00", busy, ifc.wr_uart, ifc.w_data);
    end
    n_checks++; if (na !== 8) begin n_errors++; $display("FAIL rep_count got %0d exp 8", na); end
    n_checks++; if (cyc !== 8 + stall_len) begin n_errors++; $display("FAIL rep_cycles got %0d exp %0d", cyc, 8 + stall_len); end
    next_cycle();
  endtask

  task automatic test_err_sat();
    int pops, cyc;
    logic saw_clr;
    pops = 0; cyc = 0; saw_clr = 1'b0;
    ifc.rx_empty = 1'b0; ifc.r_data = 8'h78;
    while (pops < 300 && cyc < 1000) begin
      @(negedge clk);
      if (ifc.rd_uart === 1'b1) pops++;
      if (clr === 1'b1) saw_clr = 1'b1;
      next_cycle();
      cyc++;
    end
    ifc.rx_empty = 1'b1;
    next_cycle();
    next_cycle();
    n_checks++; if (pops !== 300) begin n_errors++; $display("FAIL sat_pops got %0d exp 300", pops); end
    n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_err got %0d exp 255", err_cnt); end
    n_checks++; if (go !== 1'b1 || up !== 1'b0 || saw_clr !== 1'b0) begin
      n_errors++; $display("FAIL sat_ctl got go=%b up=%b clr_seen=%b exp 1/0/0", go, up, saw_clr);
    end
    cmd(8'h20);
    n_checks++; if (err_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_space got %0d exp 255", err_cnt); end
  endtask

  task automatic test_reset_mid_send();
    m = 4'd1; s1 = 3'd2; s0 = 4'd3; d = 4'd4;
    cmd(8'h72);
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (ifc.wr_uart !== 1'b1 || ifc.w_data !== 8'h33) begin
      n_errors++; $display("FAIL mid_idx3 got wr=%b data=%h exp 1/33", ifc.wr_uart, ifc.w_data);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ifc.wr_uart !== 1'b0 || ifc.w_data !== 8'h00) begin
      n_errors++; $display("FAIL mid_state got busy=%b wr=%b data=%h exp 0/0/00", busy, ifc.wr_uart, ifc.w_data);
    end
    n_checks++; if (go !== 1'b0 || up !== 1'b1 || err_cnt !== 8'd0) begin
      n_errors++; $display("FAIL mid_regs got go=%b up=%b err=%0d exp 0/1/0", go, up, err_cnt);
    end
    next_cycle();
    cmd(8'h67);
    n_checks++; if (go !== 1'b1) begin n_errors++; $display("FAIL post_g got %b exp 1", go); end
    cmd(8'h70);
    n_checks++; if (go !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL post_p got go=%b busy=%b exp 0/0", go, busy); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_go();
    test_back_to_back();
    test_ignore();
    test_misc();
    test_report(8, 0);
    test_report(3, 5);
    test_err_sat();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
